// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: md_op encoding and default
// multiply/divide latencies used by the multiply/divide unit.
package mips_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/execute_muldiv_if.sv
// Bundle between the ID/EX register side (master) and the multiply/divide
// unit (slave): operation request in, busy/hazard and HI/LO out.
interface execute_muldiv_if;

    mips_pkg::md_op_e md_op;
    logic             start;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             busy;
    logic             md_start_or_busy;
    logic [31:0]      hi;
    logic [31:0]      lo;

    modport master (
        output md_op, start, rs_val, rt_val,
        input  busy, md_start_or_busy, hi, lo
    );

    modport slave (
        input  md_op, start, rs_val, rt_val,
        output busy, md_start_or_busy, hi, lo
    );

endinterface

// File: rtl/muldiv_calc.sv
// Combinational multiply/divide datapath. Produces the HI/LO result for the
// requested md_op plus a divide-by-zero flag. With MULDIV_MADD_EN defined the
// multiply-accumulate family is added and the current HI/LO become inputs.
import mips_pkg::*;

module muldiv_calc (
    input  md_op_e      i_md_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
`ifdef MULDIV_MADD_EN
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
`endif
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_rt_mag_safe;
    logic [31:0] w_rt_safe;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    // Truncated 64x64 products of sign/zero-extended operands give exact 64-bit results.
    assign w_prod_s = {{32{i_rs_val[31]}}, i_rs_val} * {{32{i_rt_val[31]}}, i_rt_val};
    assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000, rem 0.
    assign w_rs_neg      = i_rs_val[31];
    assign w_rt_neg      = i_rt_val[31];
    assign w_rs_mag      = w_rs_neg ? (32'd0 - i_rs_val) : i_rs_val;
    assign w_rt_mag      = w_rt_neg ? (32'd0 - i_rt_val) : i_rt_val;
    // Zero divisors are replaced by 1 to keep the datapath defined; the result is discarded.
    assign w_rt_mag_safe = (w_rt_mag == 32'd0) ? 32'd1 : w_rt_mag;
    assign w_rt_safe     = (i_rt_val == 32'd0) ? 32'd1 : i_rt_val;
    assign w_sq_mag      = w_rs_mag / w_rt_mag_safe;
    assign w_sr_mag      = w_rs_mag % w_rt_mag_safe;
    assign w_sq          = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr          = w_rs_neg ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq          = i_rs_val / w_rt_safe;
    assign w_ur          = i_rs_val % w_rt_safe;

    // Select the HI/LO result and divide-by-zero flag for the operation.
    always_comb begin
        o_res_hi   = 32'd0;
        o_res_lo   = 32'd0;
        o_div_zero = 1'b0;
        case (i_md_op)
            MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
            MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
            MD_DIV: begin
                o_res_hi   = w_sr;
                o_res_lo   = w_sq;
                o_div_zero = (i_rt_val == 32'd0);
            end
            MD_DIVU: begin
                o_res_hi   = w_ur;
                o_res_lo   = w_uq;
                o_div_zero = (i_rt_val == 32'd0);
            end
`ifdef MULDIV_MADD_EN
            MD_MADD:  {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_s;
            MD_MADDU: {o_res_hi, o_res_lo} = {i_hi, i_lo} + w_prod_u;
            MD_MSUB:  {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_s;
            MD_MSUBU: {o_res_hi, o_res_lo} = {i_hi, i_lo} - w_prod_u;
`endif
            default: begin
                o_res_hi   = 32'd0;
                o_res_lo   = 32'd0;
                o_div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide unit. The result is computed at the start
// edge and held in pending registers; a busy counter models the multi-cycle
// latency and HI/LO are committed on the edge where the counter expires.
// Optional multiply-accumulate ops are enabled by defining MULDIV_MADD_EN.
import mips_pkg::*;

module execute_muldiv #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    execute_muldiv_if.slave   bus
);

    logic             w_is_md_op;
    logic             w_is_div;
    logic             w_accept;
    logic [CNT_W-1:0] w_lat;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_we;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    muldiv_calc u_calc (
        .i_md_op    (bus.md_op),
        .i_rs_val   (bus.rs_val),
        .i_rt_val   (bus.rt_val),
`ifdef MULDIV_MADD_EN
        .i_hi       (r_hi),
        .i_lo       (r_lo),
`endif
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    // Classify md_op: which ops launch a multi-cycle operation and which use divide latency.
    always_comb begin
        w_is_md_op = 1'b0;
        w_is_div   = 1'b0;
        case (bus.md_op)
            MD_MULT, MD_MULTU: w_is_md_op = 1'b1;
            MD_DIV, MD_DIVU: begin
                w_is_md_op = 1'b1;
                w_is_div   = 1'b1;
            end
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: w_is_md_op = 1'b1;
`endif
            default: begin
                w_is_md_op = 1'b0;
                w_is_div   = 1'b0;
            end
        endcase
    end

    assign w_accept = bus.start & w_is_md_op & ~r_busy;
    assign w_lat    = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Busy counter and pending result capture; a new start is ignored while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= w_lat;
            r_busy    <= 1'b1;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_we <= ~w_div_zero;
        end else if (r_busy) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // HI/LO: commit the pending result when the counter expires, else MTHI/MTLO when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_busy) begin
            if ((r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) && r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else begin
                r_hi <= r_hi;
            end
        end else if (bus.md_op == MD_MTHI) begin
            r_hi <= bus.rs_val;
        end else if (bus.md_op == MD_MTLO) begin
            r_lo <= bus.rs_val;
        end else begin
            r_hi <= r_hi;
        end
    end

    assign bus.busy             = r_busy;
    assign bus.md_start_or_busy = bus.start | r_busy;
    assign bus.hi               = r_hi;
    assign bus.lo               = r_lo;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: stimulus pushes the expected HI/LO and
// busy length of each launched operation; a monitor pops and compares every
// time busy falls. Directed checks cover MTHI/MTLO, ignored starts and reset.
import mips_pkg::*;

module tb_execute_muldiv;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    execute_muldiv_if bus ();

    execute_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Apply one operation for exactly one clock edge; called and returns at posedge+1.
    task automatic drive(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt, input logic st);
        bus.md_op  = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        bus.start  = st;
        @(posedge clk); #1;
        bus.md_op  = MD_NOP;
        bus.start  = 1'b0;
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t e;
        e.hi = hi; e.lo = lo; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Wait (bounded) for busy to drop, then let the monitor process the commit.
    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_idle_timeout"}, {63'd0, bus.busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: on each busy falling edge, compare HI/LO and busy length to the scoreboard.
    initial begin
        logic prev_busy;
        int   cyc;
        exp_t e;
        prev_busy = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                cyc = 0;
            end else begin
                if (bus.busy) cyc++;
                if (prev_busy && !bus.busy) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_commit", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_hi", {32'd0, bus.hi}, {32'd0, e.hi});
                        check("sb_lo", {32'd0, bus.lo}, {32'd0, e.lo});
                        check("sb_busy_cycles", 64'(cyc), 64'(e.cyc));
                    end
                    cyc = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.md_op  = MD_NOP;
        bus.start  = 1'b0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        @(posedge clk); #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MULT -2 * 3: HI/LO must hold until the commit edge.
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        drive(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        check("mult_busy_t0", {63'd0, bus.busy}, 64'd1);
        check("mult_sob_t0", {63'd0, bus.md_start_or_busy}, 64'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("mult_busy_last", {63'd0, bus.busy}, 64'd1);
        check("mult_hold_hi", {32'd0, bus.hi}, 64'd0);
        check("mult_hold_lo", {32'd0, bus.lo}, 64'd0);
        wait_idle("mult");

        // MULTU max * max.
        push(32'hFFFFFFFE, 32'h00000001, 5);
        drive(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_idle("multu");

        // DIV -7 / 2 truncates toward zero.
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        drive(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle("div");

        // Preload via MTHI/MTLO, then DIVU by zero keeps them.
        drive(MD_MTHI, 32'h00000011, 32'd0, 1'b0);
        check("mthi_val", {32'd0, bus.hi}, 64'h11);
        check("mthi_busy", {63'd0, bus.busy}, 64'd0);
        drive(MD_MTLO, 32'h00000022, 32'd0, 1'b0);
        check("mtlo_val", {32'd0, bus.lo}, 64'h22);
        push(32'h00000011, 32'h00000022, 10);
        drive(MD_DIVU, 32'd7, 32'd0, 1'b1);
        wait_idle("divu_zero");

        // MTHI while idle.
        drive(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
        check("mthi2_val", {32'd0, bus.hi}, 64'h12345678);
        check("mthi2_lo", {32'd0, bus.lo}, 64'h22);
        check("mthi2_busy", {63'd0, bus.busy}, 64'd0);

        // DIV overflow corner.
        push(32'h00000000, 32'h80000000, 10);
        drive(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_idle("div_ovf");

        // DIVU 100 / 7.
        push(32'h00000002, 32'h0000000E, 10);
        drive(MD_DIVU, 32'd100, 32'd7, 1'b1);
        wait_idle("divu");

        // DIV -100 / 7 with an ignored second start and ignored MTLO while busy.
        push(32'hFFFFFFFE, 32'hFFFFFFF2, 10);
        drive(MD_DIV, 32'hFFFFFF9C, 32'd7, 1'b1);
        drive(MD_MULT, 32'd5, 32'd5, 1'b1);
        drive(MD_MTLO, 32'h0000DEAD, 32'd0, 1'b0);
        check("busy_mtlo_ignored", {32'd0, bus.lo}, 64'hE);
        check("busy_still", {63'd0, bus.busy}, 64'd1);
        wait_idle("div_ign");

        // start with NOP is ignored.
        drive(MD_NOP, 32'd1, 32'd1, 1'b1);
        check("nop_busy", {63'd0, bus.busy}, 64'd0);
        check("nop_hi", {32'd0, bus.hi}, 64'hFFFFFFFE);
        check("nop_lo", {32'd0, bus.lo}, 64'hFFFFFFF2);

        // MADD 3*4 on {0,10}.
        drive(MD_MTHI, 32'd0, 32'd0, 1'b0);
        drive(MD_MTLO, 32'd10, 32'd0, 1'b0);
`ifdef MULDIV_MADD_EN
        push(32'd0, 32'd22, 5);
        drive(MD_MADD, 32'd3, 32'd4, 1'b1);
        wait_idle("madd");
        push(32'd0, 32'd16, 5);
        drive(MD_MSUB, 32'd2, 32'd3, 1'b1);
        wait_idle("msub");
`else
        drive(MD_MADD, 32'd3, 32'd4, 1'b1);
        check("madd_off_busy", {63'd0, bus.busy}, 64'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("madd_off_hi", {32'd0, bus.hi}, 64'd0);
        check("madd_off_lo", {32'd0, bus.lo}, 64'd10);
`endif

        // Asynchronous reset mid-MULT aborts without a later commit.
        drive(MD_MULT, 32'd6, 32'd7, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_hi", {32'd0, bus.hi}, 64'd0);
        check("arst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("post_rst_hi", {32'd0, bus.hi}, 64'd0);
        check("post_rst_lo", {32'd0, bus.lo}, 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
